// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with its own HI/LO pair.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulate ops.
module mdu_hilo #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int NMAX = (WIDTH > MUL_LAT + 1) ? WIDTH : MUL_LAT + 1;
  localparam int CW   = $clog2(NMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, len_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic             sgn_q, nq_q, nr_q, bz_q;
  logic             done_q;

  logic d_mul, d_div, d_mthi, d_mtlo, d_sgn;
`ifdef MDU_MADD_EN
  logic d_acc, d_sub;
  logic acc_q, sub_q;
`endif

  logic accept, last;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    d_mul  = 1'b0;
    d_div  = 1'b0;
    d_mthi = 1'b0;
    d_mtlo = 1'b0;
    d_sgn  = 1'b0;
`ifdef MDU_MADD_EN
    d_acc  = 1'b0;
    d_sub  = 1'b0;
`endif
    case (op)
      OP_MULT:  begin d_mul = 1'b1; d_sgn = 1'b1; end
      OP_MULTU: d_mul = 1'b1;
      OP_DIV:   begin d_div = 1'b1; d_sgn = 1'b1; end
      OP_DIVU:  d_div = 1'b1;
      OP_MTHI:  d_mthi = 1'b1;
      OP_MTLO:  d_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin d_mul = 1'b1; d_sgn = 1'b1; d_acc = 1'b1; end
      OP_MADDU: begin d_mul = 1'b1; d_acc = 1'b1; end
      OP_MSUB:  begin
        d_mul = 1'b1; d_sgn = 1'b1;
        d_acc = 1'b1; d_sub = 1'b1;
      end
      OP_MSUBU: begin d_mul = 1'b1; d_acc = 1'b1; d_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign accept = start & ~busy & ~cancel;
  assign last   = (cnt_q == len_q);

  assign a_neg = d_sgn & a[WIDTH-1];
  assign b_neg = d_sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Restoring step: quotient bits shift in at the bottom of quo_q.
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_n, quo_n, q_fin, r_fin;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, opb_q};
  assign rem_n  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_n  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign q_fin  = nq_q ? -quo_n : quo_n;
  assign r_fin  = nr_q ? -rem_n : rem_n;

  logic [2*WIDTH-1:0] pa, pb, prod, mres;

  assign pa   = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
  assign pb   = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
  assign prod = pa * pb;

`ifdef MDU_MADD_EN
  always_comb begin
    mres = prod;
    if (acc_q)
      mres = sub_q ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
  end
`else
  assign mres = prod;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept & d_mul)
          state_d = MUL;
        else if (accept & d_div)
          state_d = DIV;
      end
      default: begin
        if (cancel | last)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      len_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      sgn_q  <= 1'b0;
      nq_q   <= 1'b0;
      nr_q   <= 1'b0;
      bz_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          unique case (1'b1)
            d_mul: begin
              opa_q <= a;
              opb_q <= b;
              sgn_q <= d_sgn;
              cnt_q <= '0;
`ifdef MDU_MADD_EN
              acc_q <= d_acc;
              sub_q <= d_sub;
              len_q <= d_acc ? CW'(MUL_LAT) : CW'(MUL_LAT - 1);
`else
              len_q <= CW'(MUL_LAT - 1);
`endif
            end
            d_div: begin
              opa_q <= a;
              opb_q <= b_mag;
              quo_q <= a_mag;
              rem_q <= '0;
              nq_q  <= a_neg ^ b_neg;
              nr_q  <= a_neg;
              bz_q  <= (b == '0);
              cnt_q <= '0;
              len_q <= CW'(WIDTH - 1);
            end
            d_mthi: begin
              hi_q   <= a;
              done_q <= 1'b1;
            end
            d_mtlo: begin
              lo_q   <= a;
              done_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end else if (!cancel) begin
        cnt_q <= cnt_q + 1'b1;
        if (state_q == DIV) begin
          rem_q <= rem_n;
          quo_q <= quo_n;
        end
        if (last) begin
          done_q <= 1'b1;
          if (state_q == MUL) begin
            {hi_q, lo_q} <= mres;
          end else if (bz_q) begin
            hi_q <= opa_q;
            lo_q <= '1;
          end else begin
            hi_q <= r_fin;
            lo_q <= q_fin;
          end
        end
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
